// File: rtl/custom_axi_lite_regs.sv
// AXI4-Lite register front end for the custom IP core.
// Turns bus writes into din/enable stimulus and captures the core's result/status for software reads.
module custom_axi_lite_regs #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [ADDR_WIDTH-1:0]   s_awaddr,
   input  logic                    s_awvalid,
   output logic                    s_awready,
   input  logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_wstrb,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   output logic [1:0]              s_bresp,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   input  logic [ADDR_WIDTH-1:0]   s_araddr,
   input  logic                    s_arvalid,
   output logic                    s_arready,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output logic [1:0]              s_rresp,
   output logic                    s_rvalid,
   input  logic                    s_rready,
   output logic [15:0]             hw_din,
   output logic                    hw_enable,
   input  logic [15:0]             hw_dout,
   input  logic                    hw_valid,
   input  logic [1:0]              hw_status
);

   // state  | meaning
   // W_IDLE | waiting for AW and W together
   // W_RESP | B response presented until bready
   // R_IDLE | waiting for AR
   // R_DATA | R data presented until rready
   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_DIN    = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_DOUT   = IDX_W'(2);
   localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(3);
   localparam logic [IDX_W-1:0] IDX_LIMIT  = IDX_W'(4);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   w_state_e w_state_q, w_state_d;
   r_state_e r_state_q, r_state_d;

   logic                  ready_en_q;
   logic [1:0]            bresp_q, bresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [15:0]           din_q, din_d;
   logic [15:0]           dout_q, dout_d;
   logic                  pend_q, pend_d;
   logic                  done_q, done_d;
   logic                  ovr_q, ovr_d;
   logic                  enable_q, enable_d;

   logic                  aw_hs, ar_hs;
   logic [IDX_W-1:0]      aw_idx, ar_idx;
   logic                  aw_idx_ok, ar_idx_ok;
   logic                  wr_ctrl, wr_din, wr_status;
   logic                  start_req, pend_eff, start_ok, start_ovr;
   logic [DATA_WIDTH-1:0] rd_mux;
   logic                  unused_bits;

   assign aw_idx    = s_awaddr[ADDR_WIDTH-1:2];
   assign ar_idx    = s_araddr[ADDR_WIDTH-1:2];
   assign aw_idx_ok = aw_idx < IDX_LIMIT;
   assign ar_idx_ok = ar_idx < IDX_LIMIT;

   assign unused_bits = ^{s_awaddr[1:0], s_araddr[1:0],
                          s_wstrb[DATA_WIDTH/8-1:2], s_wdata[DATA_WIDTH-1:16]};

   // Holds all ready outputs low until the first cycle after reset is released.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ready_en_q <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         w_state_q <= W_IDLE;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         bresp_q   <= bresp_d;
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      bresp_d   = bresp_q;
      aw_hs     = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            aw_hs = ready_en_q && s_awvalid && s_wvalid;
            if (aw_hs) begin
               w_state_d = W_RESP;
               bresp_d   = aw_idx_ok ? RESP_OKAY : RESP_SLVERR;
            end
         end
         W_RESP: begin
            if (s_bready) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   assign s_awready = aw_hs;
   assign s_wready  = aw_hs;
   assign s_bvalid  = (w_state_q == W_RESP);
   assign s_bresp   = bresp_q;

   always_comb begin
      rd_mux = '0;
      case (ar_idx)
         IDX_DIN:    rd_mux = DATA_WIDTH'(din_q);
         IDX_DOUT:   rd_mux = DATA_WIDTH'(dout_q);
         IDX_STATUS: rd_mux = DATA_WIDTH'({ovr_q, done_q, pend_q, hw_status});
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      ar_hs     = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            ar_hs = ready_en_q && s_arvalid;
            if (ar_hs) begin
               r_state_d = R_DATA;
               rdata_d   = rd_mux;
               rresp_d   = ar_idx_ok ? RESP_OKAY : RESP_SLVERR;
            end
         end
         R_DATA: begin
            if (s_rready) begin
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   assign s_arready = ready_en_q && (r_state_q == R_IDLE);
   assign s_rvalid  = (r_state_q == R_DATA);
   assign s_rdata   = rdata_q;
   assign s_rresp   = rresp_q;

   assign wr_ctrl   = aw_hs && (aw_idx == IDX_CTRL);
   assign wr_din    = aw_hs && (aw_idx == IDX_DIN);
   assign wr_status = aw_hs && (aw_idx == IDX_STATUS);

   // A result arriving in the same cycle retires the old start first, so the new start is taken.
   assign start_req = wr_ctrl && s_wdata[0];
   assign pend_eff  = pend_q && !hw_valid;
   assign start_ok  = start_req && !pend_eff;
   assign start_ovr = start_req && pend_eff;

   always_comb begin
      din_d = din_q;
      if (wr_din) begin
         if (s_wstrb[0]) din_d[7:0]  = s_wdata[7:0];
         if (s_wstrb[1]) din_d[15:8] = s_wdata[15:8];
      end
      dout_d   = hw_valid ? hw_dout : dout_q;
      enable_d = start_ok;
      pend_d   = pend_q;
      if (start_ok) begin
         pend_d = 1'b1;
      end else if (hw_valid) begin
         pend_d = 1'b0;
      end
      // Set beats a same-cycle W1C clear.
      done_d = hw_valid  || (done_q && !(wr_status && s_wdata[3]));
      ovr_d  = start_ovr || (ovr_q  && !(wr_status && s_wdata[4]));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         din_q    <= '0;
         dout_q   <= '0;
         pend_q   <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         enable_q <= 1'b0;
      end else begin
         din_q    <= din_d;
         dout_q   <= dout_d;
         pend_q   <= pend_d;
         done_q   <= done_d;
         ovr_q    <= ovr_d;
         enable_q <= enable_d;
      end
   end

   assign hw_din    = din_q;
   assign hw_enable = enable_q;

endmodule

// File: tb/tb_custom_axi_lite_regs.sv
// Self-checking bench for custom_axi_lite_regs: directed map/handshake cases plus
// randomized traffic checked against a transaction-level register model.
module tb_custom_axi_lite_regs;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [5:0]  s_awaddr;
   logic        s_awvalid;
   logic        s_awready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_wvalid;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready;
   logic [5:0]  s_araddr;
   logic        s_arvalid;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready;
   logic [15:0] hw_din;
   logic        hw_enable;
   logic [15:0] hw_dout;
   logic        hw_valid;
   logic [1:0]  hw_status;

   custom_axi_lite_regs #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .hw_din(hw_din), .hw_enable(hw_enable), .hw_dout(hw_dout),
      .hw_valid(hw_valid), .hw_status(hw_status)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad = 0;

   logic [15:0] m_din, m_dout;
   logic        m_pend, m_done, m_ovr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_din = '0; m_dout = '0; m_pend = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
   endfunction

   function automatic void model_write(input logic [5:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb, input logic hv, input logic [15:0] hd,
                                       output logic exp_en, output logic [1:0] exp_resp);
      int idx;
      idx = int'(addr[5:2]);
      exp_en = 1'b0;
      exp_resp = (idx > 3) ? 2'b10 : 2'b00;
      if (hv) m_pend = 1'b0;
      case (idx)
         0: if (data[0]) begin
               if (m_pend) m_ovr = 1'b1;
               else begin m_pend = 1'b1; exp_en = 1'b1; end
            end
         1: begin
               if (strb[0]) m_din[7:0]  = data[7:0];
               if (strb[1]) m_din[15:8] = data[15:8];
            end
         3: begin
               if (data[3]) m_done = 1'b0;
               if (data[4]) m_ovr  = 1'b0;
            end
         default: ;
      endcase
      if (hv) begin m_done = 1'b1; m_dout = hd; end
   endfunction

   function automatic void model_read(input logic [5:0] addr, output logic [31:0] d,
                                      output logic [1:0] resp);
      int idx;
      idx = int'(addr[5:2]);
      resp = 2'b00;
      case (idx)
         0: d = 32'h0;
         1: d = {16'h0, m_din};
         2: d = {16'h0, m_dout};
         3: d = {27'h0, m_ovr, m_done, m_pend, hw_status};
         default: begin d = 32'h0; resp = 2'b10; end
      endcase
   endfunction

   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic hv, input logic [15:0] hd);
      logic exp_en;
      logic [1:0] exp_resp;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         s_awaddr = addr; s_wdata = data; s_wstrb = strb;
         s_awvalid = 1'b1; s_wvalid = 1'b1;
         hw_valid = hv; hw_dout = hd;
         #1;
         if (s_awready && s_wready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         check_eq("aw_timeout", 32'(s_awready), 32'd1);
         s_awvalid = 1'b0; s_wvalid = 1'b0; hw_valid = 1'b0;
         return;
      end
      model_write(addr, data, strb, hv, hd, exp_en, exp_resp);
      @(negedge clk_i);
      s_awvalid = 1'b0; s_wvalid = 1'b0; hw_valid = 1'b0; hw_dout = 16'($urandom);
      check_eq("bvalid", 32'(s_bvalid), 32'd1);
      check_eq("bresp", 32'(s_bresp), 32'(exp_resp));
      check_eq("hw_enable_pulse", 32'(hw_enable), 32'(exp_en));
      check_eq("hw_din", 32'(hw_din), 32'(m_din));
      s_bready = 1'b1;
      @(negedge clk_i);
      s_bready = 1'b0;
      check_eq("hw_enable_end", 32'(hw_enable), 32'd0);
      check_eq("bvalid_drop", 32'(s_bvalid), 32'd0);
   endtask

   task automatic axi_read(input logic [5:0] addr);
      logic [31:0] exp_d;
      logic [1:0] exp_resp;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         s_araddr = addr; s_arvalid = 1'b1;
         #1;
         if (s_arready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         check_eq("ar_timeout", 32'(s_arready), 32'd1);
         s_arvalid = 1'b0;
         return;
      end
      model_read(addr, exp_d, exp_resp);
      @(negedge clk_i);
      s_arvalid = 1'b0;
      check_eq("rvalid", 32'(s_rvalid), 32'd1);
      check_eq($sformatf("rdata@%02h", addr), s_rdata, exp_d);
      check_eq("rresp", 32'(s_rresp), 32'(exp_resp));
      s_rready = 1'b1;
      @(negedge clk_i);
      s_rready = 1'b0;
      check_eq("rvalid_drop", 32'(s_rvalid), 32'd0);
   endtask

   task automatic core_result(input logic [15:0] v);
      @(negedge clk_i);
      hw_valid = 1'b1; hw_dout = v;
      @(negedge clk_i);
      hw_valid = 1'b0; hw_dout = 16'($urandom);
      m_pend = 1'b0; m_done = 1'b1; m_dout = v;
   endtask

   function automatic logic [5:0] rand_addr();
      logic [3:0] idx;
      if ($urandom_range(0, 5) == 0) return 6'($urandom_range(16, 63));
      idx = 4'($urandom_range(0, 3));
      return {idx, 2'($urandom)};
   endfunction

   logic [31:0] hold_rdata;
   logic [1:0]  hold_rresp;
   logic        dummy_en;
   logic [1:0]  hold_bresp;

   initial begin
      rst_ni = 1'b0;
      s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
      s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
      hw_dout = 16'hA5A5; hw_valid = 1'b0; hw_status = 2'd0;
      model_reset();

      // Reset: offer transactions that must not be accepted.
      repeat (3) @(negedge clk_i);
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
      #1;
      check_eq("rst_arready", 32'(s_arready), 32'd0);
      check_eq("rst_awready", 32'(s_awready), 32'd0);
      check_eq("rst_bvalid", 32'(s_bvalid), 32'd0);
      check_eq("rst_rvalid", 32'(s_rvalid), 32'd0);
      check_eq("rst_hw_enable", 32'(hw_enable), 32'd0);
      check_eq("rst_hw_din", 32'(hw_din), 32'd0);
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check_eq("arready_pre_rise", 32'(s_arready), 32'd0);
      @(negedge clk_i);
      check_eq("arready_rise", 32'(s_arready), 32'd1);

      axi_read(6'h00); axi_read(6'h04); axi_read(6'h08); axi_read(6'h0C);

      axi_write(6'h04, 32'h0000_BEEF, 4'b0001, 1'b0, 16'h0);
      axi_write(6'h04, 32'h0000_BEEF, 4'b0010, 1'b0, 16'h0);
      axi_read(6'h04);

      axi_write(6'h00, 32'h1, 4'hF, 1'b0, 16'h0);
      axi_read(6'h0C);
      core_result(16'h1234);
      axi_read(6'h08);
      axi_read(6'h0C);

      axi_write(6'h00, 32'h1, 4'hF, 1'b0, 16'h0);
      axi_write(6'h00, 32'h1, 4'hF, 1'b0, 16'h0);
      axi_read(6'h0C);
      axi_write(6'h0C, 32'h18, 4'hF, 1'b0, 16'h0);
      axi_read(6'h0C);

      axi_write(6'h10, 32'hFFFF_FFFF, 4'hF, 1'b0, 16'h0);
      axi_read(6'h10);
      axi_read(6'h04);
      axi_read(6'h0C);

      // Same-cycle START + result while pending, then W1C DONE + result.
      axi_write(6'h00, 32'h1, 4'hF, 1'b1, 16'h5678);
      axi_read(6'h0C);
      axi_write(6'h0C, 32'h08, 4'hF, 1'b1, 16'h9ABC);
      axi_read(6'h0C);
      axi_read(6'h08);

      // Hold B and R with new transactions offered, then reset mid-hold.
      @(negedge clk_i);
      hw_status = 2'd2;
      s_awaddr = 6'h04; s_wdata = 32'h0000_C3D2; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      s_araddr = 6'h0C; s_arvalid = 1'b1;
      #1;
      check_eq("hold_aw_accept", 32'(s_awready), 32'd1);
      check_eq("hold_ar_accept", 32'(s_arready), 32'd1);
      model_read(6'h0C, hold_rdata, hold_rresp);
      model_write(6'h04, 32'h0000_C3D2, 4'hF, 1'b0, 16'h0, dummy_en, hold_bresp);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         #1;
         check_eq("hold_bvalid", 32'(s_bvalid), 32'd1);
         check_eq("hold_bresp", 32'(s_bresp), 32'(hold_bresp));
         check_eq("hold_rvalid", 32'(s_rvalid), 32'd1);
         check_eq("hold_rdata", s_rdata, hold_rdata);
         check_eq("hold_awready", 32'(s_awready), 32'd0);
         check_eq("hold_arready", 32'(s_arready), 32'd0);
      end
      check_eq("hold_hw_din", 32'(hw_din), 32'(m_din));
      rst_ni = 1'b0;
      @(negedge clk_i);
      check_eq("midrst_bvalid", 32'(s_bvalid), 32'd0);
      check_eq("midrst_rvalid", 32'(s_rvalid), 32'd0);
      check_eq("midrst_hw_din", 32'(hw_din), 32'd0);
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      rst_ni = 1'b1;
      model_reset();
      axi_read(6'h0C);
      axi_read(6'h08);

      for (int n = 0; n < 400; n++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if (op <= 2) begin
            axi_write(rand_addr(), $urandom, 4'($urandom), ($urandom_range(0, 4) == 0),
                      16'($urandom));
         end else if (op <= 6) begin
            axi_read(rand_addr());
         end else if (op <= 8) begin
            core_result(16'($urandom));
         end else begin
            @(negedge clk_i);
            hw_status = 2'($urandom);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

endmodule
